// File: rtl/bram_arbiter_if.sv
// Request/response and BRAM-side signal bundle for the two-port BRAM arbiter.
// slave = arbiter view, master = requesters plus the BRAM they share.
interface bram_arbiter_if #(
    parameter int WIDTH_BITS = 32,
    parameter int ADDRWIDTH  = 6
);
    logic                  i_vld_0;
    logic                  i_we_0;
    logic [ADDRWIDTH-1:0]  i_addr_0;
    logic [WIDTH_BITS-1:0] i_wd_0;
    logic                  o_rdy_0;
    logic                  o_rsp_vld_0;
    logic [WIDTH_BITS-1:0] o_rsp_rd_0;

    logic                  i_vld_1;
    logic                  i_we_1;
    logic [ADDRWIDTH-1:0]  i_addr_1;
    logic [WIDTH_BITS-1:0] i_wd_1;
    logic                  o_rdy_1;
    logic                  o_rsp_vld_1;
    logic [WIDTH_BITS-1:0] o_rsp_rd_1;

    logic                  o_bram_en;
    logic                  o_bram_we;
    logic [ADDRWIDTH-1:0]  o_bram_addr;
    logic [WIDTH_BITS-1:0] o_bram_wd;
    logic [WIDTH_BITS-1:0] i_bram_rd;

    // Handshake: a request transfers in any cycle where i_vld_k && o_rdy_k; the
    // requester holds all request fields stable until then. o_rsp_vld_k is a
    // one-cycle pulse with no back-pressure, one cycle after the transfer.
    modport slave (
        input  i_vld_0, i_we_0, i_addr_0, i_wd_0,
        input  i_vld_1, i_we_1, i_addr_1, i_wd_1,
        input  i_bram_rd,
        output o_rdy_0, o_rsp_vld_0, o_rsp_rd_0,
        output o_rdy_1, o_rsp_vld_1, o_rsp_rd_1,
        output o_bram_en, o_bram_we, o_bram_addr, o_bram_wd
    );

    modport master (
        output i_vld_0, i_we_0, i_addr_0, i_wd_0,
        output i_vld_1, i_we_1, i_addr_1, i_wd_1,
        output i_bram_rd,
        input  o_rdy_0, o_rsp_vld_0, o_rsp_rd_0,
        input  o_rdy_1, o_rsp_vld_1, o_rsp_rd_1,
        input  o_bram_en, o_bram_we, o_bram_addr, o_bram_wd
    );
endinterface

// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM with a
// one-cycle read latency; responses are routed back by a registered tag.
module bram_arbiter #(
    parameter int WIDTH_BITS = 32,
    parameter int ADDRWIDTH  = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    bram_arbiter_if.slave   bus,
    output logic            o_dbg_rr_ptr
);

    logic rr_ptr;
    logic gnt_0;
    logic gnt_1;
    logic tag_vld;
    logic tag_id;
    logic tag_we;

    // Grants are masked by reset so the BRAM sees no traffic while held in reset.
    always_comb begin
        gnt_0 = 1'b0;
        gnt_1 = 1'b0;
        if (i_rst_n) begin
            if (bus.i_vld_0 && bus.i_vld_1) begin
                gnt_0 = ~rr_ptr;
                gnt_1 = rr_ptr;
            end else begin
                gnt_0 = bus.i_vld_0;
                gnt_1 = bus.i_vld_1;
            end
        end
    end

    assign bus.o_rdy_0  = gnt_0;
    assign bus.o_rdy_1  = gnt_1;
    assign o_dbg_rr_ptr = rr_ptr;

    always_comb begin
        bus.o_bram_en   = 1'b0;
        bus.o_bram_we   = 1'b0;
        bus.o_bram_addr = '0;
        bus.o_bram_wd   = '0;
        if (gnt_0) begin
            bus.o_bram_en   = 1'b1;
            bus.o_bram_we   = bus.i_we_0;
            bus.o_bram_addr = bus.i_addr_0;
            bus.o_bram_wd   = bus.i_wd_0;
        end else if (gnt_1) begin
            bus.o_bram_en   = 1'b1;
            bus.o_bram_we   = bus.i_we_1;
            bus.o_bram_addr = bus.i_addr_1;
            bus.o_bram_wd   = bus.i_wd_1;
        end
    end

    // Pointer moves to the loser of each accepted request, so contention alternates.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr  <= 1'b0;
            tag_vld <= 1'b0;
            tag_id  <= 1'b0;
            tag_we  <= 1'b0;
        end else begin
            if (gnt_0) begin
                rr_ptr <= 1'b1;
            end else if (gnt_1) begin
                rr_ptr <= 1'b0;
            end
            tag_vld <= gnt_0 | gnt_1;
            tag_id  <= gnt_1;
            tag_we  <= (gnt_0 & bus.i_we_0) | (gnt_1 & bus.i_we_1);
        end
    end

    // Write responses carry zero: the BRAM output is stale during a write.
    always_comb begin
        bus.o_rsp_vld_0 = tag_vld & ~tag_id;
        bus.o_rsp_vld_1 = tag_vld & tag_id;
        bus.o_rsp_rd_0  = '0;
        bus.o_rsp_rd_1  = '0;
        if (bus.o_rsp_vld_0 && !tag_we) begin
            bus.o_rsp_rd_0 = bus.i_bram_rd;
        end
        if (bus.o_rsp_vld_1 && !tag_we) begin
            bus.o_rsp_rd_1 = bus.i_bram_rd;
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed-vector and randomized-handshake bench for bram_arbiter, with a
// behavioural BRAM model (registered read, zero when disabled, stale on write).
module tb_bram_arbiter;
    localparam int W  = 32;
    localparam int AW = 6;

    typedef struct {
        logic          v0;
        logic          w0;
        logic [AW-1:0] a0;
        logic [W-1:0]  d0;
        logic          v1;
        logic          w1;
        logic [AW-1:0] a1;
        logic [W-1:0]  d1;
        logic          rdy0;
        logic          rdy1;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [W-1:0]  wd;
        logic          rv0;
        logic [W-1:0]  rd0;
        logic          rv1;
        logic [W-1:0]  rd1;
        logic          rr;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_arbiter_if #(.WIDTH_BITS(W), .ADDRWIDTH(AW)) bif ();
    logic dbg_rr;

    bram_arbiter #(.WIDTH_BITS(W), .ADDRWIDTH(AW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .bus          (bif),
        .o_dbg_rr_ptr (dbg_rr)
    );

    // ---------------- BRAM model ----------------
    logic [W-1:0] mem [2**AW];
    logic [W-1:0] bram_rd = '0;
    assign bif.i_bram_rd = bram_rd;

    always @(posedge clk) begin
        if (bif.o_bram_en) begin
            if (bif.o_bram_we) mem[bif.o_bram_addr] <= bif.o_bram_wd;
            else               bram_rd <= mem[bif.o_bram_addr];
        end else begin
            bram_rd <= '0;
        end
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    vec_t vecs[14];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        bif.i_vld_0 = v.v0; bif.i_we_0 = v.w0; bif.i_addr_0 = v.a0; bif.i_wd_0 = v.d0;
        bif.i_vld_1 = v.v1; bif.i_we_1 = v.w1; bif.i_addr_1 = v.a1; bif.i_wd_1 = v.d1;
    endtask

    task automatic drive_idle();
        bif.i_vld_0 = 1'b0; bif.i_we_0 = 1'b0; bif.i_addr_0 = '0; bif.i_wd_0 = '0;
        bif.i_vld_1 = 1'b0; bif.i_we_1 = 1'b0; bif.i_addr_1 = '0; bif.i_wd_1 = '0;
    endtask

    task automatic check_vec(input vec_t v, input int i);
        chk($sformatf("v%0d rdy0", i), W'(bif.o_rdy_0), W'(v.rdy0));
        chk($sformatf("v%0d rdy1", i), W'(bif.o_rdy_1), W'(v.rdy1));
        chk($sformatf("v%0d en", i), W'(bif.o_bram_en), W'(v.en));
        chk($sformatf("v%0d we", i), W'(bif.o_bram_we), W'(v.we));
        chk($sformatf("v%0d addr", i), W'(bif.o_bram_addr), W'(v.addr));
        chk($sformatf("v%0d wd", i), bif.o_bram_wd, v.wd);
        chk($sformatf("v%0d rsp_vld0", i), W'(bif.o_rsp_vld_0), W'(v.rv0));
        chk($sformatf("v%0d rsp_rd0", i), bif.o_rsp_rd_0, v.rd0);
        chk($sformatf("v%0d rsp_vld1", i), W'(bif.o_rsp_vld_1), W'(v.rv1));
        chk($sformatf("v%0d rsp_rd1", i), bif.o_rsp_rd_1, v.rd1);
        chk($sformatf("v%0d rr_ptr", i), W'(dbg_rr), W'(v.rr));
    endtask

    // Pops expected responses and checks data; zero data required when idle.
    task automatic check_responses(input string tag);
        if (bif.o_rsp_vld_0) begin
            if (exp_q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s unexpected rsp0: got %h expected none", tag, bif.o_rsp_rd_0);
            end else begin
                chk({tag, " rsp_rd0"}, bif.o_rsp_rd_0, exp_q0.pop_front());
            end
        end else begin
            chk({tag, " idle rd0"}, bif.o_rsp_rd_0, '0);
        end
        if (bif.o_rsp_vld_1) begin
            if (exp_q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL %s unexpected rsp1: got %h expected none", tag, bif.o_rsp_rd_1);
            end else begin
                chk({tag, " rsp_rd1"}, bif.o_rsp_rd_1, exp_q1.pop_front());
            end
        end else begin
            chk({tag, " idle rd1"}, bif.o_rsp_rd_1, '0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int acc0, acc1, rsp0, rsp1;
        logic hold0, hold1;

        for (int i = 0; i < 2**AW; i++) mem[i] = 32'h1000_0000 + W'(i);

        // Field order: v0 w0 a0 d0 | v1 w1 a1 d1 | rdy0 rdy1 en we addr wd | rv0 rd0 | rv1 rd1 | rr
        vecs[0]  = '{1'b1,1'b0,6'd1,32'h0, 1'b1,1'b0,6'd2,32'h0, 1'b1,1'b0,1'b1,1'b0,6'd1,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
        vecs[1]  = '{1'b1,1'b0,6'd1,32'h0, 1'b1,1'b0,6'd2,32'h0, 1'b0,1'b1,1'b1,1'b0,6'd2,32'h0, 1'b1,32'h1000_0001, 1'b0,32'h0, 1'b1};
        vecs[2]  = '{1'b1,1'b0,6'd1,32'h0, 1'b1,1'b0,6'd2,32'h0, 1'b1,1'b0,1'b1,1'b0,6'd1,32'h0, 1'b0,32'h0, 1'b1,32'h1000_0002, 1'b0};
        vecs[3]  = '{1'b1,1'b0,6'd1,32'h0, 1'b1,1'b0,6'd2,32'h0, 1'b0,1'b1,1'b1,1'b0,6'd2,32'h0, 1'b1,32'h1000_0001, 1'b0,32'h0, 1'b1};
        vecs[4]  = '{1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,1'b0,1'b0,6'd0,32'h0, 1'b0,32'h0, 1'b1,32'h1000_0002, 1'b0};
        vecs[5]  = '{1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,1'b0,1'b0,6'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
        vecs[6]  = vecs[5];
        vecs[7]  = vecs[5];
        vecs[8]  = '{1'b1,1'b1,6'd5,32'hDEAD_BEEF, 1'b0,1'b0,6'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,6'd5,32'hDEAD_BEEF, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
        vecs[9]  = '{1'b1,1'b0,6'd5,32'h0, 1'b0,1'b0,6'd0,32'h0, 1'b1,1'b0,1'b1,1'b0,6'd5,32'h0, 1'b1,32'h0, 1'b0,32'h0, 1'b1};
        vecs[10] = '{1'b1,1'b1,6'd63,32'h0000_00A5, 1'b0,1'b0,6'd0,32'h0, 1'b1,1'b0,1'b1,1'b1,6'd63,32'h0000_00A5, 1'b1,32'hDEAD_BEEF, 1'b0,32'h0, 1'b1};
        vecs[11] = '{1'b0,1'b0,6'd0,32'h0, 1'b1,1'b0,6'd63,32'h0, 1'b0,1'b1,1'b1,1'b0,6'd63,32'h0, 1'b1,32'h0, 1'b0,32'h0, 1'b1};
        vecs[12] = '{1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,6'd0,32'h0, 1'b0,1'b0,1'b0,1'b0,6'd0,32'h0, 1'b0,32'h0, 1'b1,32'h0000_00A5, 1'b0};
        vecs[13] = vecs[5];

        // Reset state, with both requesters asserting valid during reset
        drive_idle();
        bif.i_vld_0 = 1'b1; bif.i_we_0 = 1'b1;
        bif.i_vld_1 = 1'b1; bif.i_we_1 = 1'b1;
        @(negedge clk);
        chk("rst en", W'(bif.o_bram_en), '0);
        chk("rst we", W'(bif.o_bram_we), '0);
        chk("rst rdy0", W'(bif.o_rdy_0), '0);
        chk("rst rdy1", W'(bif.o_rdy_1), '0);
        chk("rst rsp_vld0", W'(bif.o_rsp_vld_0), '0);
        chk("rst rsp_vld1", W'(bif.o_rsp_vld_1), '0);
        chk("rst rr_ptr", W'(dbg_rr), '0);
        @(posedge clk); #1;
        drive_idle();
        rst_n = 1'b1;

        // Directed table: contention, idle, write-then-read, cross-requester
        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check_vec(vecs[i], i);
            @(posedge clk); #1;
        end

        // Reset pulsed mid-cycle while a req1 read response is showing
        drive_idle();
        bif.i_vld_1 = 1'b1; bif.i_addr_1 = 6'd2;
        @(negedge clk);
        chk("rr1 rdy1", W'(bif.o_rdy_1), W'(1'b1));
        @(posedge clk); #1;
        drive_idle();
        #2;
        chk("rr1 rsp_vld1 before rst", W'(bif.o_rsp_vld_1), W'(1'b1));
        chk("rr1 rsp_rd1 before rst", bif.o_rsp_rd_1, 32'h1000_0002);
        rst_n = 1'b0;
        #1;
        chk("rr1 rsp_vld1 in rst", W'(bif.o_rsp_vld_1), '0);
        chk("rr1 rsp_rd1 in rst", bif.o_rsp_rd_1, '0);
        chk("rr1 rr_ptr in rst", W'(dbg_rr), '0);
        bif.i_vld_0 = 1'b1; bif.i_we_0 = 1'b1; bif.i_vld_1 = 1'b1;
        #1;
        chk("rr1 en in rst", W'(bif.o_bram_en), '0);
        chk("rr1 we in rst", W'(bif.o_bram_we), '0);
        @(posedge clk); #1;
        drive_idle();
        #3;
        rst_n = 1'b1;
        bif.i_vld_0 = 1'b1; bif.i_addr_0 = 6'd1;
        @(negedge clk);
        chk("post-rst rdy0", W'(bif.o_rdy_0), W'(1'b1));
        chk("post-rst en", W'(bif.o_bram_en), W'(1'b1));
        chk("post-rst rsp_vld1", W'(bif.o_rsp_vld_1), '0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("post-rst rsp_vld0", W'(bif.o_rsp_vld_0), W'(1'b1));
        chk("post-rst rsp_rd0", bif.o_rsp_rd_0, 32'h1000_0001);
        chk("post-rst no rsp1", W'(bif.o_rsp_vld_1), '0);
        @(negedge clk);
        chk("post-rst quiet0", W'(bif.o_rsp_vld_0), '0);
        chk("post-rst quiet1", W'(bif.o_rsp_vld_1), '0);
        @(posedge clk); #1;

        // Randomized handshake: requests held until accepted
        acc0 = 0; acc1 = 0; rsp0 = 0; rsp1 = 0;
        hold0 = 1'b0; hold1 = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (!hold0) begin
                bif.i_vld_0  = 1'($urandom_range(0, 1));
                bif.i_we_0   = 1'($urandom_range(0, 1));
                bif.i_addr_0 = AW'($urandom_range(0, 2**AW - 1));
                bif.i_wd_0   = $urandom;
            end
            if (!hold1) begin
                bif.i_vld_1  = 1'($urandom_range(0, 1));
                bif.i_we_1   = 1'($urandom_range(0, 1));
                bif.i_addr_1 = AW'($urandom_range(0, 2**AW - 1));
                bif.i_wd_1   = $urandom;
            end
            @(negedge clk);
            chk("rand rdy exclusive", W'(bif.o_rdy_0 && bif.o_rdy_1), '0);
            chk("rand rdy0 without vld", W'(bif.o_rdy_0 && !bif.i_vld_0), '0);
            chk("rand rdy1 without vld", W'(bif.o_rdy_1 && !bif.i_vld_1), '0);
            if (bif.o_rsp_vld_0) rsp0++;
            if (bif.o_rsp_vld_1) rsp1++;
            check_responses("rand");
            if (bif.i_vld_0 && bif.o_rdy_0) begin
                acc0++;
                exp_q0.push_back(bif.i_we_0 ? '0 : mem[bif.i_addr_0]);
                hold0 = 1'b0;
            end else begin
                hold0 = bif.i_vld_0;
            end
            if (bif.i_vld_1 && bif.o_rdy_1) begin
                acc1++;
                exp_q1.push_back(bif.i_we_1 ? '0 : mem[bif.i_addr_1]);
                hold1 = 1'b0;
            end else begin
                hold1 = bif.i_vld_1;
            end
            @(posedge clk); #1;
        end
        drive_idle();
        @(negedge clk);
        if (bif.o_rsp_vld_0) rsp0++;
        if (bif.o_rsp_vld_1) rsp1++;
        check_responses("drain");
        chk("rand count0", W'(rsp0), W'(acc0));
        chk("rand count1", W'(rsp1), W'(acc1));
        chk("rand q0 empty", W'(exp_q0.size()), '0);
        chk("rand q1 empty", W'(exp_q1.size()), '0);

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH_BITS, default 32, the data word width.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 6, the word address width of the shared BRAM.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset. The ports are i_clk (input, 1, rising-edge clock) and i_rst_n (input, 1, asynchronous active-low reset).
REQ-004 For each requester k in {0,1}, the block SHALL have these ports:
- i_vld_k, input, 1: request valid.
- i_we_k, input, 1: 1 = write, 0 = read.
- i_addr_k, input, ADDRWIDTH: word address.
- i_wd_k, input, WIDTH_BITS: write data.
- o_rdy_k, output, 1: request accepted this cycle.
- o_rsp_vld_k, output, 1: response valid.
- o_rsp_rd_k, output, WIDTH_BITS: response data.
REQ-005 The block SHALL have these BRAM-side ports:
- o_bram_en, output, 1: BRAM enable.
- o_bram_we, output, 1: BRAM write enable.
- o_bram_addr, output, ADDRWIDTH: BRAM address.
- o_bram_wd, output, WIDTH_BITS: BRAM write data.
- i_bram_rd, input, WIDTH_BITS: BRAM read data, registered one cycle after the read request; the BRAM returns 0 for any cycle in which enable was low.

Function
REQ-006 A request from requester k SHALL be accepted in a cycle where i_vld_k && o_rdy_k; at most one of o_rdy_0 and o_rdy_1 SHALL be high in any cycle.
REQ-007 The grant SHALL be decided combinationally:
- Only one i_vld_k high: grant that k.
- Both high: grant the requester indicated by the round-robin pointer rr_ptr.
- Neither high: no grant.
REQ-008 o_rdy_k SHALL equal the grant to k; o_rdy_k SHALL never be high when i_vld_k is low.
REQ-009 On any accepted request, rr_ptr SHALL update at the clock edge to the requester that was not granted; with no accepted request, rr_ptr SHALL hold.
REQ-010 In a grant cycle, the BRAM-side outputs SHALL be driven combinationally from the granted requester:
- o_bram_en = 1.
- o_bram_we = i_we_k.
- o_bram_addr = i_addr_k.
- o_bram_wd = i_wd_k.
REQ-011 With no grant, the BRAM-side outputs SHALL be o_bram_en = 0, o_bram_we = 0, o_bram_addr = 0 and o_bram_wd = 0.
REQ-012 The block SHALL register a response tag (valid, requester id, is_write) on every accepted request; the tag valid bit SHALL clear in cycles with no acceptance.
REQ-013 Response latency SHALL be exactly 1 cycle: a request accepted in cycle N SHALL assert o_rsp_vld_k for exactly one cycle, in cycle N+1.
REQ-014 For a read response, o_rsp_rd_k SHALL equal i_bram_rd in cycle N+1.
REQ-015 For a write response, o_rsp_rd_k SHALL be 0, because the BRAM holds its stale output on writes.
REQ-016 o_rsp_vld_k SHALL be low and o_rsp_rd_k SHALL be 0 whenever the registered tag does not select requester k.
REQ-017 Back-to-back acceptances SHALL be supported every cycle with no bubble, and responses SHALL return in acceptance order.
REQ-018 A read accepted in the cycle immediately after a write to the same address SHALL return the newly written data.
REQ-019 A requester SHALL hold i_vld_k, i_we_k, i_addr_k and i_wd_k stable until accepted; the block SHALL NOT latch unaccepted requests.
REQ-020 Under continuous contention, neither requester SHALL wait more than 1 cycle between acceptances.

Reset
REQ-021 While i_rst_n = 0, asynchronously:
- rr_ptr SHALL be 0.
- The response tag SHALL be cleared.
- Every o_rsp_vld_k SHALL be 0 and every o_rsp_rd_k SHALL be 0.
- o_bram_en and o_bram_we SHALL be 0 regardless of the i_vld_k inputs.
REQ-022 A response pending when reset asserts SHALL be discarded and SHALL NOT be emitted after reset releases.
REQ-023 The first grant after reset release SHALL take effect in the first cycle with i_rst_n = 1.
REQ-024 The arbiter SHALL NOT clear BRAM contents on reset.

Verification
REQ-025 The bench SHALL cover a single requester doing a write then a read: req0 writes 0xDEADBEEF to address 5 in cycle N, then reads address 5 in cycle N+1 -> write response in N+1 with o_rsp_rd_0 = 0, then o_rsp_vld_0 in N+2 with o_rsp_rd_0 = 0xDEADBEEF.
REQ-026 The bench SHALL cover contention after reset: both requesters read continuously for 4 cycles (req0 address 1, req1 address 2) -> grants 0,1,0,1 and responses alternating on the two ports, one cycle after each grant.
REQ-027 The bench SHALL cover the idle case: no valid for 3 cycles -> o_bram_en = 0, o_rsp_vld_0 = o_rsp_vld_1 = 0, o_rsp_rd_0 = o_rsp_rd_1 = 0, and rr_ptr unchanged.
REQ-028 The bench SHALL cover reset during a read: req1 read accepted in cycle N, i_rst_n pulsed low mid-cycle N+1 -> o_rsp_vld_1 drops to 0 immediately and no response follows after release.
REQ-029 The bench SHALL cover a cross-requester write-then-read: req0 writes 0x0000_00A5 to address 63 with only req0 valid, then req1 reads address 63 in the next cycle -> o_rsp_vld_1 high with o_rsp_rd_1 = 0x0000_00A5.
REQ-030 The bench SHALL cover the rdy/vld invariant: randomized valid, 1000 cycles -> o_rdy_0 && o_rdy_1 never true, and the count of o_rsp_vld_k equals the count of acceptances for requester k.
